// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing and
// sizing helpers shared by the timing generator.
package vga_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_CHAR_W = 8;
  localparam int DEF_CHAR_H = 16;

  function automatic int axisTotal(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

  // never narrower than one bit, even for n<=2
  function automatic int cntW(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one raster axis
// with visible, sync and last-visible window decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS  = DEF_H_VIS,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP,
  localparam int TOTAL = axisTotal(VIS, FP, SYNC, BP),
  localparam int W     = cntW(TOTAL)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         visWin,
  output logic         syncWin,
  output logic         lastVis
);

  localparam logic [W:0] LAST  = (W+1)'(TOTAL - 1);
  localparam logic [W:0] VEND  = (W+1)'(VIS);
  localparam logic [W:0] SBEG  = (W+1)'(VIS + FP);
  localparam logic [W:0] SEND  = (W+1)'(VIS + FP + SYNC);
  localparam logic [W:0] VLAST = (W+1)'(VIS - 1);

  logic [W:0] cntX;

  assign cntX    = {1'b0, cnt};
  assign wrap    = adv && (cntX == LAST);
  assign visWin  = cntX < VEND;
  assign syncWin = (cntX >= SBEG) && (cntX < SEND);
  assign lastVis = cntX == VLAST;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_text_timing.sv
// vga_text_timing: VGA raster timing with character
// cell tracking, sync polarity and frame/blink count.
module vga_text_timing
  import vga_pkg::*;
#(
  parameter int H_VIS     = DEF_H_VIS,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VIS     = DEF_V_VIS,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int CHAR_H    = DEF_CHAR_H,
  parameter int BLINK_BIT = 4,
  localparam int H_TOTAL =
    axisTotal(H_VIS, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL =
    axisTotal(V_VIS, V_FP, V_SYNC, V_BP),
  localparam int HW  = cntW(H_TOTAL),
  localparam int VW  = cntW(V_TOTAL),
  localparam int CW  = cntW(H_VIS / CHAR_W),
  localparam int RW  = cntW(V_VIS / CHAR_H),
  localparam int GXW = cntW(CHAR_W),
  localparam int GYW = cntW(CHAR_H)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           pixEn,
  output logic           hSync,
  output logic           vSync,
  output logic           vis,
  output logic [HW-1:0]  hCount,
  output logic [VW-1:0]  vCount,
  output logic [CW-1:0]  col,
  output logic [RW-1:0]  row,
  output logic [GXW-1:0] glyphX,
  output logic [GYW-1:0] glyphY,
  output logic           lineStart,
  output logic           frameStart,
  output logic [7:0]     frameCount,
  output logic           blink
);

  if (H_VIS % CHAR_W != 0) begin : gBadW
    $error("H_VIS must be a multiple of CHAR_W");
  end
  if (V_VIS % CHAR_H != 0) begin : gBadH
    $error("V_VIS must be a multiple of CHAR_H");
  end
  if (CHAR_W < 2 || CHAR_H < 2) begin : gBadCell
    $error("CHAR_W and CHAR_H must be >= 2");
  end
  if (BLINK_BIT < 0 || BLINK_BIT > 7) begin : gBadBlink
    $error("BLINK_BIT must index frameCount");
  end

  localparam logic [GXW-1:0] GX_LAST = GXW'(CHAR_W - 1);
  localparam logic [GYW-1:0] GY_LAST = GYW'(CHAR_H - 1);

  logic [HW-1:0]  hc;
  logic [VW-1:0]  vc;
  logic           hWrap;
  logic           vWrap;
  logic           hVisW;
  logic           vVisW;
  logic           hSyncW;
  logic           vSyncW;
  logic           hLastVis;
  logic           vLastVis;
  logic [GXW-1:0] gx;
  logic [GYW-1:0] gy;
  logic [CW-1:0]  colC;
  logic [RW-1:0]  rowC;
  logic [7:0]     fc;

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP)
  ) uHAxis (
    .clk    (clk),
    .nrst   (nrst),
    .adv    (pixEn),
    .cnt    (hc),
    .wrap   (hWrap),
    .visWin (hVisW),
    .syncWin(hSyncW),
    .lastVis(hLastVis)
  );

  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP)
  ) uVAxis (
    .clk    (clk),
    .nrst   (nrst),
    .adv    (hWrap),
    .cnt    (vc),
    .wrap   (vWrap),
    .visWin (vVisW),
    .syncWin(vSyncW),
    .lastVis(vLastVis)
  );

  // cell counters track the live hc/vc, zero outside
  // the visible window so they restart cleanly
  always_ff @(posedge clk) begin
    if (!nrst) begin
      gx   <= '0;
      colC <= '0;
    end else if (pixEn) begin
      if (!hVisW || hLastVis) begin
        gx   <= '0;
        colC <= '0;
      end else if (gx == GX_LAST) begin
        gx   <= '0;
        colC <= colC + CW'(1);
      end else begin
        gx <= gx + GXW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      gy   <= '0;
      rowC <= '0;
    end else if (hWrap) begin
      if (!vVisW || vLastVis) begin
        gy   <= '0;
        rowC <= '0;
      end else if (gy == GY_LAST) begin
        gy   <= '0;
        rowC <= rowC + RW'(1);
      end else begin
        gy <= gy + GYW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fc <= '0;
    end else if (vWrap) begin
      fc <= fc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hSync      <= ~HSYNC_POL;
      vSync      <= ~VSYNC_POL;
      vis        <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      col        <= '0;
      row        <= '0;
      glyphX     <= '0;
      glyphY     <= '0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      frameCount <= '0;
      blink      <= 1'b0;
    end else if (pixEn) begin
      hSync      <= hSyncW ? HSYNC_POL : ~HSYNC_POL;
      vSync      <= vSyncW ? VSYNC_POL : ~VSYNC_POL;
      vis        <= hVisW && vVisW;
      hCount     <= hc;
      vCount     <= vc;
      col        <= colC;
      row        <= rowC;
      glyphX     <= gx;
      glyphY     <= gy;
      lineStart  <= hc == '0;
      frameStart <= (hc == '0) && (vc == '0);
      frameCount <= fc;
      blink      <= fc[BLINK_BIT];
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_text_timing.sv
// tb_vga_text_timing: default and small-config DUTs
// against an arithmetic raster model via scoreboard.
module tb_vga_text_timing;

  typedef struct {
    int hv; int hfp; int hsw; int hbp;
    int vv; int vfp; int vsw; int vbp;
    int cw; int ch; int bb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    int hc; int vc; int col; int row;
    int gx; int gy; int fc;
    bit vis; bit hs; bit vs;
    bit ls; bit fs; bit bl;
  } out_t;

  typedef struct {
    int   pos;
    int   fr;
    out_t o;
  } mst_t;

  logic clk = 1'b0;
  logic nrst;
  logic pixEn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       dHs, dVs, dVis, dLs, dFs, dBl;
  logic [9:0] dH, dV;
  logic [6:0] dCol;
  logic [4:0] dRow;
  logic [2:0] dGx;
  logic [3:0] dGy;
  logic [7:0] dFc;

  logic       sHs, sVs, sVis, sLs, sFs, sBl;
  logic [4:0] sH;
  logic [2:0] sV;
  logic [1:0] sCol;
  logic [0:0] sRow;
  logic [1:0] sGx;
  logic [0:0] sGy;
  logic [7:0] sFc;

  vga_text_timing dutD (
    .clk(clk), .nrst(nrst), .pixEn(pixEn),
    .hSync(dHs), .vSync(dVs), .vis(dVis),
    .hCount(dH), .vCount(dV),
    .col(dCol), .row(dRow),
    .glyphX(dGx), .glyphY(dGy),
    .lineStart(dLs), .frameStart(dFs),
    .frameCount(dFc), .blink(dBl)
  );

  vga_text_timing #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .CHAR_W(4), .CHAR_H(2), .BLINK_BIT(4)
  ) dutS (
    .clk(clk), .nrst(nrst), .pixEn(pixEn),
    .hSync(sHs), .vSync(sVs), .vis(sVis),
    .hCount(sH), .vCount(sV),
    .col(sCol), .row(sRow),
    .glyphX(sGx), .glyphY(sGy),
    .lineStart(sLs), .frameStart(sFs),
    .frameCount(sFc), .blink(sBl)
  );

  cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33,
               8, 16, 4, 1'b0, 1'b0};
  cfg_t CS = '{16, 2, 3, 3, 4, 1, 1, 1,
               4, 2, 4, 1'b1, 1'b1};

  function automatic int hTot(cfg_t c);
    return c.hv + c.hfp + c.hsw + c.hbp;
  endfunction

  function automatic int vTot(cfg_t c);
    return c.vv + c.vfp + c.vsw + c.vbp;
  endfunction

  function automatic out_t rstOut(cfg_t c);
    out_t o;
    o = '{default: 0};
    o.hs = !c.hp;
    o.vs = !c.vp;
    return o;
  endfunction

  // what the display should show at raster position pos
  function automatic out_t decode(cfg_t c, int pos, int fr);
    out_t o;
    int h;
    int v;
    h = pos % hTot(c);
    v = pos / hTot(c);
    o.hc  = h;
    o.vc  = v;
    o.vis = (h < c.hv) && (v < c.vv);
    o.hs  = (h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hsw)
            ? c.hp : !c.hp;
    o.vs  = (v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vsw)
            ? c.vp : !c.vp;
    o.col = (h < c.hv) ? h / c.cw : 0;
    o.gx  = (h < c.hv) ? h % c.cw : 0;
    o.row = (v < c.vv) ? v / c.ch : 0;
    o.gy  = (v < c.vv) ? v % c.ch : 0;
    o.ls  = (h == 0);
    o.fs  = (pos == 0);
    o.fc  = fr % 256;
    o.bl  = ((o.fc >> c.bb) & 1) != 0;
    return o;
  endfunction

  function automatic mst_t step(cfg_t c, mst_t s,
                                bit rn, bit en);
    mst_t n;
    n = s;
    if (!rn) begin
      n.pos = 0;
      n.fr  = 0;
      n.o   = rstOut(c);
    end else if (en) begin
      n.o   = decode(c, s.pos, s.fr);
      n.pos = s.pos + 1;
      if (n.pos == hTot(c) * vTot(c)) begin
        n.pos = 0;
        n.fr  = s.fr + 1;
      end
    end else begin
      n.o.ls = 1'b0;
      n.o.fs = 1'b0;
    end
    return n;
  endfunction

  task automatic cmp(string nm, integer act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  mst_t stD;
  mst_t stS;
  out_t qD[$];
  out_t qS[$];

  initial begin
    stD = '{0, 0, '{default: 0}};
    stS = '{0, 0, '{default: 0}};
  end

  always @(posedge clk) begin
    stD = step(CD, stD, nrst, pixEn);
    qD.push_back(stD.o);
    stS = step(CS, stS, nrst, pixEn);
    qS.push_back(stS.o);
  end

  always @(posedge clk) begin
    out_t e;
    #1;
    if (qD.size() == 0 || qS.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end else begin
      e = qD.pop_front();
      cmp("D.hCount", dH, e.hc);
      cmp("D.vCount", dV, e.vc);
      cmp("D.col", dCol, e.col);
      cmp("D.row", dRow, e.row);
      cmp("D.glyphX", dGx, e.gx);
      cmp("D.glyphY", dGy, e.gy);
      cmp("D.frameCount", dFc, e.fc);
      cmp("D.vis", dVis, int'(e.vis));
      cmp("D.hSync", dHs, int'(e.hs));
      cmp("D.vSync", dVs, int'(e.vs));
      cmp("D.lineStart", dLs, int'(e.ls));
      cmp("D.frameStart", dFs, int'(e.fs));
      cmp("D.blink", dBl, int'(e.bl));
      e = qS.pop_front();
      cmp("S.hCount", sH, e.hc);
      cmp("S.vCount", sV, e.vc);
      cmp("S.col", sCol, e.col);
      cmp("S.row", sRow, e.row);
      cmp("S.glyphX", sGx, e.gx);
      cmp("S.glyphY", sGy, e.gy);
      cmp("S.frameCount", sFc, e.fc);
      cmp("S.vis", sVis, int'(e.vis));
      cmp("S.hSync", sHs, int'(e.hs));
      cmp("S.vSync", sVs, int'(e.vs));
      cmp("S.lineStart", sLs, int'(e.ls));
      cmp("S.frameStart", sFs, int'(e.fs));
      cmp("S.blink", sBl, int'(e.bl));
    end
  end

  task automatic waitLs(output int at);
    at = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (dLs === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  initial begin
    int t1;
    int t2;
    int fsCnt;
    bit hit;
    nrst  = 1'b0;
    pixEn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pixEn = 1'($urandom_range(0, 1));
    end
    cmp("rst.hSync", dHs, 1);
    cmp("rst.vSync", dVs, 1);

    // free-running: 17 small frames
    nrst  = 1'b1;
    pixEn = 1'b1;
    fsCnt = 0;
    repeat (16 * 168) begin
      @(negedge clk);
      if (sFs === 1'b1) fsCnt++;
    end
    cmp("S.frameStarts", fsCnt, 16);
    cmp("S.fc15", sFc, 15);
    cmp("S.blinkLow", sBl, 0);
    @(negedge clk);
    cmp("S.fc16", sFc, 16);
    cmp("S.blinkHigh", sBl, 1);
    cmp("S.fs16", sFs, 1);

    waitLs(t1);
    waitLs(t2);
    cmp("D.linePeriod", t2 - t1, 800);

    // half-rate enable
    fork
      begin
        repeat (4000) begin
          @(negedge clk);
          pixEn = ~pixEn;
        end
      end
      begin
        waitLs(t1);
        @(negedge clk);
        cmp("D.lineWidth", dLs, 0);
        waitLs(t2);
        cmp("D.linePeriodHalf", t2 - t1, 1600);
      end
    join

    // mid-line reset at hCount=300
    pixEn = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (dH == 10'd300) hit = 1'b1;
    end
    cmp("D.reach300", int'(hit), 1);
    nrst = 1'b0;
    @(negedge clk);
    cmp("D.rstH", dH, 0);
    cmp("D.rstVis", dVis, 0);
    nrst = 1'b1;
    @(negedge clk);
    cmp("D.relFs", dFs, 1);
    @(negedge clk);
    cmp("D.relH1", dH, 1);

    // random enable with occasional reset
    repeat (3000) begin
      @(negedge clk);
      pixEn = ($urandom_range(0, 3) != 0);
      nrst  = ($urandom_range(0, 399) != 0);
    end
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_timing.md
# vga_text_timing

Parametrised VGA raster timing generator for text-mode displays. It combines horizontal/vertical counting and sync decode in one block, and adds character-cell tracking (column, row, in-glyph pixel/scanline), a pixel-clock enable, configurable sync polarity, and a frame counter with a cursor/attribute blink output. It sits between the dot-clock buffer and the character-fetch/pixel-output stages of the display pipeline.

## Interface
- H_VIS, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync and back porch widths in pixels
- V_VIS, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch, sync and back porch widths in lines
- HSYNC_POL, 0 / VSYNC_POL, 0: active level of each sync output
- CHAR_W, 8 / CHAR_H, 16: glyph cell size; each must be ≥2
- BLINK_BIT, 4: frameCount bit that drives blink
- clk  in  1  dot clock
- nrst  in  1  synchronous, active-low reset
- pixEn  in  1  pixel advance enable
- hSync, vSync  out  1  sync outputs at the configured polarity
- vis  out  1  pixel is inside the visible area
- hCount  out  $clog2(H_TOTAL)  current pixel position
- vCount  out  $clog2(V_TOTAL)  current line position
- col, row  out  $clog2(H_VIS/CHAR_W), $clog2(V_VIS/CHAR_H)  character cell coordinates
- glyphX, glyphY  out  $clog2(CHAR_W), $clog2(CHAR_H)  position of the pixel inside its cell
- lineStart, frameStart  out  1  one-cycle pulses marking the start of a line and of a frame
- frameCount  out  8  completed-frame counter
- blink  out  1  equals frameCount[BLINK_BIT]

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way from the vertical parameters.
- Each line is laid out as visible [0,H_VIS), then front porch, then sync at [H_VIS+H_FP, H_VIS+H_FP+H_SYNC), then back porch. Vertical lines follow the same layout.
- Internal counters hc and vc advance only on edges where pixEn=1.
  - hc wraps from H_TOTAL-1 to 0.
  - vc increments on each hc wrap and wraps from V_TOTAL-1 to 0.
- Glyph tracking uses incremental counters, never division:
  - glyphX counts 0..CHAR_W-1 while hc<H_VIS; col increments when glyphX wraps.
  - When hc≥H_VIS, col and glyphX read 0.
  - glyphY and row advance on the hc wrap of each visible line, glyphY wrapping at CHAR_H.
  - When vc≥V_VIS, row and glyphY read 0.
- frameCount increments by 1 (mod 256) when hc and vc both wrap together.
- Elaboration fails if H_VIS mod CHAR_W≠0 or V_VIS mod CHAR_H≠0.

## Timing
- All outputs are registered. On an edge with pixEn=1, every output takes its decode of the pre-edge (hc,vc), so outputs lag the counters by one enabled edge and are mutually aligned.
- lineStart is high for the one cycle after an enabled edge that decoded hc=0. frameStart is the same but also requires vc=0.
- On any edge with pixEn=0, all outputs hold except lineStart and frameStart, which go to 0.
- Reset (nrst=0 at an edge) is valid at any time, including mid-line; it overrides pixEn. It forces:
  - hc=vc=0 and all count/coordinate outputs to 0
  - vis=0, lineStart=0, frameStart=0, blink=0, frameCount=0
  - hSync=~HSYNC_POL, vSync=~VSYNC_POL
- The first enabled edge after reset release outputs the decode for (0,0): vis=1, lineStart=1, frameStart=1.
- A simultaneous hc wrap and vc wrap produces a single frameCount increment.

## Structure
- Package vga_pkg holds the default 640x480@60 timing constants and a total/width function used for port sizing.
- Sub-module vga_axis_counter is instantiated twice (horizontal and vertical). It is a generic wrap counter with an advance input, wrap output and visible/sync window decode.
- The top level owns the glyph counters, the frame counter and the output registers.

## Test plan
- Reset, then hold nrst=0 for 5 cycles -> all outputs at their reset values; hSync=vSync=1 with default polarity.
- Defaults with pixEn=1 -> vis=1 for 640 cycles per line; hSync=0 exactly while hCount is 656..751; at hCount=639, col=79 and glyphX=7; the line period is 800 cycles.
- Small configuration (H 16/2/3/3, V 4/1/1/1, CHAR 4x2, polarity 1) -> hSync=1 at hCount 18..20; vSync=1 on line 5; row=1 and glyphY=1 on line 3; the frame period is 168 cycles.
- pixEn toggling 1,0,1,0 -> counters advance every other cycle; lineStart lasts exactly 1 clk; the line period becomes 2×H_TOTAL clocks.
- Run 17 small frames -> frameCount reaches 16 and blink rises at the frame-16 wrap; frameStart fires exactly once per frame.
- Assert reset at hCount=300, vCount=200 -> reset values on the next edge; after release, hCount runs from 0 and frameStart pulses.
